// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault_code bit positions and monitor state enum.
package traffic_pkg;

  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampDark   = 3'b000;

  localparam int unsigned FcIllegal  = 0;
  localparam int unsigned FcConflict = 1;
  localparam int unsigned FcTimeout  = 2;

  typedef enum logic [1:0] {
    StInit  = 2'b00,
    StPass  = 2'b01,
    StFault = 2'b10
  } mon_state_e;

  function automatic logic lamp_legal(input logic [2:0] code);
    return (code == LampGreen) || (code == LampYellow) || (code == LampRed);
  endfunction

endpackage

// File: rtl/traffic_light_conflict_monitor_if.sv
// Controller commands in, monitored lamp drive and status out.
interface traffic_light_conflict_monitor_if;

  logic [2:0] road_a;
  logic [2:0] road_b;
  logic [2:0] road_c;
  logic       clear_fault;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic [2:0] lamp_c;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] mon_state;

  modport master (
    output road_a, road_b, road_c, clear_fault,
    input  lamp_a, lamp_b, lamp_c, fault, fault_code, mon_state
  );

  modport slave (
    input  road_a, road_b, road_c, clear_fault,
    output lamp_a, lamp_b, lamp_c, fault, fault_code, mon_state
  );

endinterface

// File: rtl/go_timeout_counter.sv
// Per-road count of consecutive non-red cycles, saturating at MAX_GO_CYCLES.
module go_timeout_counter #(
  parameter int unsigned MAX_GO_CYCLES = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic active,   // monitor in PASS and staying there this cycle
  input  logic nonred,
  output logic at_max
);

  localparam int unsigned CntW = $clog2(MAX_GO_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == CntW'(MAX_GO_CYCLES));

  // Count while non-red, clear on red or whenever the monitor is not passing.
  always_comb begin
    cnt_d = '0;
    if (active && nonred) begin
      cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_light_conflict_monitor.sv
// Safety monitor between a traffic controller and three roads' lamps.
module traffic_light_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 8,
  parameter int unsigned MAX_GO_CYCLES  = 40,
  parameter int unsigned FLASH_HALF     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  traffic_light_conflict_monitor_if.slave  bus
);

  localparam int unsigned StartW = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned FlashW = $clog2(FLASH_HALF + 1);

  mon_state_e        state_q, state_d;
  logic [2:0]        lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d, lamp_c_q, lamp_c_d;
  logic [2:0]        fault_code_q, fault_code_d;
  logic [StartW-1:0] startup_q, startup_d;
  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
  logic              flash_dark_q, flash_dark_d;

  logic       nonred_a, nonred_b, nonred_c;
  logic       max_a, max_b, max_c;
  logic [2:0] fail_code;
  logic       any_fail;
  logic       go_active;

  assign nonred_a  = (bus.road_a != LampRed);
  assign nonred_b  = (bus.road_b != LampRed);
  assign nonred_c  = (bus.road_c != LampRed);
  assign go_active = (state_q == StPass) && !any_fail;

  go_timeout_counter #(.MAX_GO_CYCLES(MAX_GO_CYCLES)) u_go_a (
    .clk(clk), .rst(rst), .active(go_active), .nonred(nonred_a), .at_max(max_a)
  );
  go_timeout_counter #(.MAX_GO_CYCLES(MAX_GO_CYCLES)) u_go_b (
    .clk(clk), .rst(rst), .active(go_active), .nonred(nonred_b), .at_max(max_b)
  );
  go_timeout_counter #(.MAX_GO_CYCLES(MAX_GO_CYCLES)) u_go_c (
    .clk(clk), .rst(rst), .active(go_active), .nonred(nonred_c), .at_max(max_c)
  );

  // Safety checks on the current inputs; only acted on in PASS.
  always_comb begin
    fail_code = '0;
    fail_code[FcIllegal]  = !lamp_legal(bus.road_a) || !lamp_legal(bus.road_b) ||
                            !lamp_legal(bus.road_c);
    fail_code[FcConflict] = (nonred_a && nonred_b) || (nonred_a && nonred_c) ||
                            (nonred_b && nonred_c);
    fail_code[FcTimeout]  = (nonred_a && max_a) || (nonred_b && max_b) || (nonred_c && max_c);
    any_fail = |fail_code;
  end

  // Next-state, lamp and fault-code logic; lamps default to all red.
  always_comb begin
    state_d      = state_q;
    lamp_a_d     = LampRed;
    lamp_b_d     = LampRed;
    lamp_c_d     = LampRed;
    fault_code_d = fault_code_q;
    startup_d    = '0;
    flash_cnt_d  = '0;
    flash_dark_d = 1'b0;
    case (state_q)
      StInit: begin
        fault_code_d = '0;
        if (startup_q == StartW'(STARTUP_CYCLES - 1)) state_d = StPass;
        else                                          startup_d = startup_q + 1'b1;
      end
      StPass: begin
        if (any_fail) begin
          // Offending pattern is blocked; flashing starts on the red half.
          state_d      = StFault;
          fault_code_d = fail_code;
        end else begin
          lamp_a_d = bus.road_a;
          lamp_b_d = bus.road_b;
          lamp_c_d = bus.road_c;
        end
      end
      StFault: begin
        if (bus.clear_fault && !nonred_a && !nonred_b && !nonred_c) begin
          state_d      = StInit;
          fault_code_d = '0;
        end else begin
          if (flash_cnt_q == FlashW'(FLASH_HALF - 1)) begin
            flash_dark_d = !flash_dark_q;
          end else begin
            flash_cnt_d  = flash_cnt_q + 1'b1;
            flash_dark_d = flash_dark_q;
          end
          if (flash_dark_d) begin
            lamp_a_d = LampDark;
            lamp_b_d = LampDark;
            lamp_c_d = LampDark;
          end
        end
      end
      default: begin
        state_d      = StInit;
        fault_code_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      lamp_a_q     <= LampRed;
      lamp_b_q     <= LampRed;
      lamp_c_q     <= LampRed;
      fault_code_q <= '0;
      startup_q    <= '0;
      flash_cnt_q  <= '0;
      flash_dark_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lamp_a_q     <= lamp_a_d;
      lamp_b_q     <= lamp_b_d;
      lamp_c_q     <= lamp_c_d;
      fault_code_q <= fault_code_d;
      startup_q    <= startup_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_dark_q <= flash_dark_d;
    end
  end

  assign bus.lamp_a     = lamp_a_q;
  assign bus.lamp_b     = lamp_b_q;
  assign bus.lamp_c     = lamp_c_q;
  assign bus.fault      = (state_q == StFault);
  assign bus.fault_code = fault_code_q;
  assign bus.mon_state  = state_q;

endmodule

// File: tb/tb_traffic_light_conflict_monitor.sv
// Bench for traffic_light_conflict_monitor: table vectors in PASS plus
// hand-written fault, flash, clear and reset sequences.
module tb_traffic_light_conflict_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;
  localparam logic [1:0] S_INIT  = 2'b00;
  localparam logic [1:0] S_PASS  = 2'b01;
  localparam logic [1:0] S_FAULT = 2'b10;

  typedef struct packed {
    logic [2:0] la, lb, lc;
    logic       f;
    logic [2:0] fc;
    logic [1:0] st;
  } exp_t;

  typedef struct packed {
    logic [2:0] ra, rb, rc;
    logic       clr;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  vec_t vecs[8];

  traffic_light_conflict_monitor_if bus ();

  traffic_light_conflict_monitor #(
    .STARTUP_CYCLES(8),
    .MAX_GO_CYCLES (40),
    .FLASH_HALF    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [2:0] la, lb, lc, input logic f,
                              input logic [2:0] fc, input logic [1:0] st);
    exp_t e;
    e.la = la; e.lb = lb; e.lc = lc; e.f = f; e.fc = fc; e.st = st;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [2:0] ra, rb, rc, input logic clr);
    vec_t v;
    v.ra = ra; v.rb = rb; v.rc = rc; v.clr = clr;
    v.e = ex(ra, rb, rc, 1'b0, 3'b000, S_PASS);
    return v;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input logic [2:0] ra, rb, rc, input logic clr, rs,
                      input exp_t e, input string tag);
    exp_t w;
    bus.road_a = ra; bus.road_b = rb; bus.road_c = rc;
    bus.clear_fault = clr;
    rst = rs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    chk({tag, ".lamp_a"}, bus.lamp_a, w.la);
    chk({tag, ".lamp_b"}, bus.lamp_b, w.lb);
    chk({tag, ".lamp_c"}, bus.lamp_c, w.lc);
    chk({tag, ".fault"}, {2'b00, bus.fault}, {2'b00, w.f});
    chk({tag, ".fault_code"}, bus.fault_code, w.fc);
    chk({tag, ".mon_state"}, {1'b0, bus.mon_state}, {1'b0, w.st});
  endtask

  // Seven more INIT cycles after the entry edge, then PASS on the eighth.
  task automatic init_wait(input logic clr, input string tag);
    for (int i = 1; i <= 8; i++)
      step(R, R, R, clr, 1'b0, ex(R, R, R, 1'b0, 3'b000, (i == 8) ? S_PASS : S_INIT), tag);
  endtask

  function automatic logic [2:0] flash(input int p);
    return ((p / 4) % 2 == 1) ? D : R;
  endfunction

  initial begin
    vecs[0] = mkv(Y, R, R, 1'b0);
    vecs[1] = mkv(R, G, R, 1'b0);
    vecs[2] = mkv(R, Y, R, 1'b1);
    vecs[3] = mkv(R, R, G, 1'b0);
    vecs[4] = mkv(R, R, Y, 1'b1);
    vecs[5] = mkv(R, R, R, 1'b0);
    vecs[6] = mkv(G, R, R, 1'b0);
    vecs[7] = mkv(R, R, R, 1'b1);

    // Reset state.
    step(G, R, R, 1'b0, 1'b1, ex(R, R, R, 1'b0, 3'b000, S_INIT), "reset");
    step(G, R, R, 1'b1, 1'b1, ex(R, R, R, 1'b0, 3'b000, S_INIT), "reset_clr");

    // Startup: all red through INIT, PASS on cycle 9, green a cycle later.
    for (int i = 1; i <= 8; i++)
      step(G, R, R, 1'b0, 1'b0, ex(R, R, R, 1'b0, 3'b000, (i == 8) ? S_PASS : S_INIT),
           "startup");
    step(G, R, R, 1'b0, 1'b0, ex(G, R, R, 1'b0, 3'b000, S_PASS), "first_pass");

    // Legal single-road patterns pass through; clear_fault has no effect.
    for (int i = 0; i < 8; i++)
      step(vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].clr, 1'b0, vecs[i].e, "table");

    // Conflict, then clear straight back to INIT.
    step(G, Y, R, 1'b0, 1'b0, ex(R, R, R, 1'b1, 3'b010, S_FAULT), "conflict");
    step(R, R, R, 1'b1, 1'b0, ex(R, R, R, 1'b0, 3'b000, S_INIT), "clear1");
    init_wait(1'b1, "init_clr");

    // Illegal plus conflict; code holds, non-red clear ignored, clear in dark phase.
    step(G, 3'b011, R, 1'b0, 1'b0, ex(R, R, R, 1'b1, 3'b011, S_FAULT), "illegal");
    step(G, Y, R, 1'b0, 1'b0, ex(R, R, R, 1'b1, 3'b011, S_FAULT), "code_hold");
    step(G, R, R, 1'b1, 1'b0, ex(R, R, R, 1'b1, 3'b011, S_FAULT), "clr_ignored");
    step(R, R, R, 1'b0, 1'b0, ex(R, R, R, 1'b1, 3'b011, S_FAULT), "flash_r");
    step(R, R, R, 1'b0, 1'b0, ex(D, D, D, 1'b1, 3'b011, S_FAULT), "flash_d");
    step(R, R, R, 1'b1, 1'b0, ex(R, R, R, 1'b0, 3'b000, S_INIT), "clear2");
    init_wait(1'b0, "init2");

    // Go timeout: 40 greens pass, the 41st faults, then flash 4 red / 4 dark.
    for (int i = 1; i <= 40; i++)
      step(G, R, R, 1'b0, 1'b0, ex(G, R, R, 1'b0, 3'b000, S_PASS), "go_pass");
    step(G, R, R, 1'b0, 1'b0, ex(R, R, R, 1'b1, 3'b100, S_FAULT), "timeout");
    for (int p = 1; p <= 13; p++) begin
      logic [2:0] l;
      l = flash(p);
      step(R, R, R, 1'b0, 1'b0, ex(l, l, l, 1'b1, 3'b100, S_FAULT), "flash");
    end

    // Reset during the dark phase (p=14) wins over clear_fault.
    step(R, R, R, 1'b1, 1'b1, ex(R, R, R, 1'b0, 3'b000, S_INIT), "rst_fault");
    init_wait(1'b0, "init3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_conflict_monitor.md
TRAFFIC_LIGHT_CONFLICT_MONITOR -- requirements
Module: traffic_light_conflict_monitor

Interface
REQ-001 Parameter STARTUP_CYCLES, default 8: all-red cycles forced after reset or fault clear.
REQ-002 Parameter MAX_GO_CYCLES, default 40: max consecutive non-red cycles allowed per road.
REQ-003 Parameter FLASH_HALF, default 4: cycles per half-period of fault flashing.
REQ-004 clk  input  1  sole clock, all flops rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 road_a, road_b, road_c  input  3 each  controller lamp commands: 001 green, 010 yellow, 100 red.
REQ-007 clear_fault  input  1  operator request to leave fault state.
REQ-008 lamp_a, lamp_b, lamp_c  output  3 each  registered lamp drive, same encoding as inputs; 000 = dark.
REQ-009 fault  output  1  high while in FAULT.
REQ-010 fault_code  output  3  bit0 illegal code, bit1 conflict, bit2 go-timeout.
REQ-011 mon_state  output  2  00 INIT, 01 PASS, 10 FAULT.

Function
REQ-012 The FSM SHALL have states INIT, PASS, FAULT; no other encodings reachable, and any unused encoding SHALL go to INIT.
REQ-013 In INIT, lamps SHALL all be 100 and a startup counter SHALL run; after STARTUP_CYCLES cycles in INIT the FSM SHALL enter PASS; checks are not evaluated in INIT.
REQ-014 In PASS, checks SHALL be evaluated combinationally on the current inputs each cycle.
REQ-015 Illegal: any road input not in {001,010,100}.
REQ-016 Conflict: more than one road input not equal to 100 in the same cycle.
REQ-017 Timeout: a road is non-red in a cycle where its go-counter already equals MAX_GO_CYCLES, i.e. on the (MAX_GO_CYCLES+1)th consecutive non-red cycle.
REQ-018 Go-counters SHALL increment while their road is non-red in PASS, clear to 0 in a cycle the road is red, saturate at MAX_GO_CYCLES, and hold 0 in INIT and FAULT; width SHALL be clog2(MAX_GO_CYCLES+1).
REQ-019 In PASS with no check failing, lamps SHALL register the inputs (1-cycle latency).
REQ-020 In PASS with any check failing, at that edge lamps SHALL load 100/100/100, fault_code SHALL load all failing bits simultaneously, and FSM SHALL enter FAULT; an offending pattern SHALL never reach the lamps.
REQ-021 In FAULT, all three lamps SHALL be 100 for FLASH_HALF cycles then 000 for FLASH_HALF cycles, repeating, starting with 100 at the entry edge.
REQ-022 fault_code SHALL hold its entry value throughout FAULT; new failures SHALL not alter it.
REQ-023 In FAULT, clear_fault=1 with all three inputs equal to 100 SHALL move to INIT next edge, clearing fault and fault_code; clear_fault with any input non-red SHALL be ignored.
REQ-024 clear_fault SHALL have no effect in INIT or PASS.

Reset
REQ-025 rst=1 at any edge, in any state, SHALL force INIT, lamps 100/100/100, fault=0, fault_code=000, all counters 0; rst takes priority over clear_fault and checks.

Structure
REQ-026 Lamp encodings, fault_code bit positions and the state enum SHALL live in shared package traffic_pkg.
REQ-027 The per-road counter SHALL be sub-module go_timeout_counter, instantiated three times.

Verification
REQ-028 Reset then inputs 001/100/100 -> lamps 100/100/100 for 8 cycles, mon_state=01 on cycle 9, lamps 001/100/100 one cycle after.
REQ-029 In PASS, inputs 001/010/100 -> lamps stay 100/100/100, fault=1, fault_code=010 at that edge.
REQ-030 In PASS, road_b=011 with road_a=001 -> fault_code=011 (illegal and conflict).
REQ-031 road_a held 001 for 41 cycles -> 40 cycles passed through, fault_code=100 on the 41st; lamps flash 100x4, 000x4.
REQ-032 In FAULT, clear_fault=1 with road_a=001 -> ignored; then with 100/100/100 -> INIT, fault=0, fault_code=000, 8 all-red cycles.
REQ-033 rst asserted mid-FAULT during 000 flash phase -> next edge lamps 100/100/100, mon_state=00, fault=0.
